// File: rtl/rom_loader_pkg.sv
// Shared definitions for the program-ROM loader: loader states,
// default frame parameters and a small sizing helper.
package rom_loader_pkg;

    localparam int         DEFAULT_WORD_WIDTH = 24;
    localparam int         DEFAULT_ADDR_BITS  = 8;
    localparam logic [7:0] DEFAULT_SYNC_BYTE  = 8'hA5;
    localparam int         BYTES_PER_WORD     = DEFAULT_WORD_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    // Width of a counter that has to hold values 0..n-1, never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input handshake plus program-memory write port and
// load-status outputs of the ROM loader.
interface rom_loader_if
    import rom_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    // Host side: drives the byte stream, observes memory writes and status.
    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/rom_loader_word_assembler.sv
// Packs consecutive bytes, MSB byte first, into one program word and
// flags when the byte being offered is the last one of the word.
module rom_loader_word_assembler
    import rom_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_complete
);
    localparam int               BPW      = WORD_WIDTH / 8;
    localparam int               IDX_W    = index_width(BPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0] byte_idx;

    assign word_complete = (byte_idx == LAST_IDX);

    // Shift new bytes in at the bottom and track the position inside the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= (word << 8) | WORD_WIDTH'(byte_in);
            byte_idx <= word_complete ? '0 : byte_idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/rom_loader.sv
// Writer side of the program ROM: parses SYNC/CNT/words/CHK frames from a
// byte stream, writes the words sequentially and releases the core only
// after the checksum of a complete image has matched.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int         ADDR_BITS  = DEFAULT_ADDR_BITS,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input logic        clk,
    input logic        rst,
    rom_loader_if.slave bus
);
    loader_state_t         state, next_state;
    logic [7:0]            word_cnt;
    logic [7:0]            word_idx;
    logic [7:0]            checksum;
    logic                  in_ready;
    logic                  accept;
    logic                  wr_en;
    logic                  shift_en;
    logic                  clear_idx;
    logic                  word_complete;
    logic [WORD_WIDTH-1:0] word;

    // The write cycle is the only one in which no byte can be taken.
    assign in_ready = (state != WRITE);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = word_idx[ADDR_BITS-1:0];
    assign bus.wr_data  = word;
    assign bus.cpu_hold = (state != DONE);
    assign bus.done     = (state == DONE);
    assign bus.error    = (state == ERR);

    rom_loader_word_assembler #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_assembler (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear_idx),
        .shift_en      (shift_en),
        .byte_in       (bus.in_data),
        .word          (word),
        .word_complete (word_complete)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Frame sequencing and per-state strobes.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        shift_en   = 1'b0;
        clear_idx  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (accept && bus.in_data == SYNC_BYTE) next_state = COUNT;
            end
            COUNT: begin
                if (accept) begin
                    clear_idx  = 1'b1;
                    next_state = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (word_complete) next_state = WRITE;
                end
            end
            WRITE: begin
                wr_en      = 1'b1;
                next_state = (word_idx == word_cnt) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) next_state = (bus.in_data == checksum) ? DONE : ERR;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word count, write index and running checksum of CNT plus all data bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            word_idx <= '0;
            checksum <= '0;
        end else begin
            case (state)
                COUNT: begin
                    if (accept) begin
                        word_cnt <= bus.in_data;
                        checksum <= bus.in_data;
                        word_idx <= '0;
                    end
                end
                DATA: begin
                    if (accept) checksum <= checksum + bus.in_data;
                end
                WRITE: word_idx <= word_idx + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table of frames with expected status,
// scoreboard of expected memory writes, plus reset and wrap-around sequences.
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int WW = 24;
    localparam int AB = 8;

    typedef struct {
        logic [7:0]       cnt;
        logic [2:0][23:0] w;
        logic [7:0]       chk_xor;
        int               max_gap;
        bit               stray;
        bit               exp_done;
        bit               exp_error;
    } vec_t;

    typedef struct packed {
        logic [AB-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   checks = 0;
    int   passed = 0;
    wr_t  sb[$];
    logic [23:0] frame_words[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    rom_loader_if #(.WORD_WIDTH(WW), .ADDR_BITS(AB)) bus();

    rom_loader #(
        .WORD_WIDTH (WW),
        .ADDR_BITS  (AB),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    function automatic vec_t mkVec(input logic [7:0] cnt, input logic [23:0] w0, input logic [23:0] w1,
                                   input logic [23:0] w2, input logic [7:0] chk_xor, input int max_gap,
                                   input bit stray, input bit exp_done, input bit exp_error);
        vec_t v;
        v.cnt = cnt;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.chk_xor = chk_xor;
        v.max_gap = max_gap;
        v.stray = stray;
        v.exp_done = exp_done;
        v.exp_error = exp_error;
        return v;
    endfunction

    // Pop one expected write for every strobe the DUT produces.
    always @(negedge clk) begin
        wr_t exp;
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                checkOutput("wr_addr", 32'(bus.wr_addr), 32'(exp.addr));
                checkOutput("wr_data", 32'(bus.wr_data), 32'(exp.data));
                checkOutput("in_ready during write", 32'(bus.in_ready), 32'd0);
            end
        end
    end

    // Offer one byte at a negedge and return at the negedge after it transferred.
    task automatic sendByte(input logic [7:0] b);
        int guard = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("in_ready wait", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idleGap(input int max_gap);
        if (max_gap > 0) repeat ($urandom_range(1, max_gap)) @(negedge clk);
    endtask

    // Send one complete frame built from frame_words and check writes and final status.
    task automatic applyStimulus(input logic [7:0] cnt, input logic [7:0] chk_xor, input int max_gap,
                                 input bit stray, input bit exp_done, input bit exp_error);
        logic [7:0]  chk;
        logic [23:0] w;
        int          guard;
        chk = cnt;
        if (stray) begin
            sendByte(8'h00);
            sendByte(8'hFF);
        end
        sendByte(8'hA5);
        idleGap(max_gap);
        sendByte(cnt);
        idleGap(max_gap);
        for (int k = 0; k <= int'(cnt); k++) begin
            w = frame_words[k];
            for (int b = 2; b >= 0; b--) begin
                chk = chk + w[8*b +: 8];
                if (b == 0) sb.push_back('{addr: AB'(k), data: w});
                sendByte(w[8*b +: 8]);
                checkOutput("in_ready after data byte", 32'(bus.in_ready), (b == 0) ? 32'd0 : 32'd1);
                idleGap(max_gap);
            end
        end
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wr_addr before CHK", 32'(bus.wr_addr), 32'(AB'(int'(cnt) + 1)));
        checkOutput("cpu_hold before CHK", 32'(bus.cpu_hold), 32'd1);
        sendByte(chk ^ chk_xor);
        checkOutput("done", 32'(bus.done), 32'(exp_done));
        checkOutput("error", 32'(bus.error), 32'(exp_error));
        checkOutput("cpu_hold", 32'(bus.cpu_hold), 32'(!exp_done));
        checkOutput("all writes seen", 32'(sb.size()), 32'd0);
    endtask

    task automatic loadVec(input vec_t v);
        frame_words.delete();
        for (int k = 0; k <= int'(v.cnt); k++) frame_words.push_back(v.w[k]);
        applyStimulus(v.cnt, v.chk_xor, v.max_gap, v.stray, v.exp_done, v.exp_error);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        checkOutput({tag, " wr_en"},    32'(bus.wr_en),    32'd0);
        checkOutput({tag, " wr_addr"},  32'(bus.wr_addr),  32'd0);
        checkOutput({tag, " wr_data"},  32'(bus.wr_data),  32'd0);
        checkOutput({tag, " cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
        checkOutput({tag, " done"},     32'(bus.done),     32'd0);
        checkOutput({tag, " error"},    32'(bus.error),    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = mkVec(8'd0, 24'h123456, 24'h0,      24'h0,      8'h00, 0, 1'b0, 1'b1, 1'b0);
        vecs[1] = mkVec(8'd1, 24'h010203, 24'h040506, 24'h0,      8'h00, 0, 1'b0, 1'b1, 1'b0);
        vecs[2] = mkVec(8'd1, 24'h010203, 24'h040506, 24'h0,      8'h01, 0, 1'b0, 1'b0, 1'b1);
        vecs[3] = mkVec(8'd1, 24'h010203, 24'h040506, 24'h0,      8'h00, 0, 1'b0, 1'b1, 1'b0);
        vecs[4] = mkVec(8'd1, 24'h010203, 24'h040506, 24'h0,      8'h00, 5, 1'b1, 1'b1, 1'b0);
        vecs[5] = mkVec(8'd2, 24'hA5A5A5, 24'h00FF00, 24'hFFFFFF, 8'h00, 3, 1'b1, 1'b1, 1'b0);
        vecs[6] = mkVec(8'd0, 24'h000000, 24'h0,      24'h0,      8'h80, 0, 1'b0, 1'b0, 1'b1);

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("in reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkResetValues("idle");

        for (int i = 0; i < 7; i++) loadVec(vecs[i]);

        // Reset in the middle of a word, then a full frame from IDLE with stray bytes.
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h11);
        sendByte(8'h22);
        rst = 1'b1;
        #1;
        checkResetValues("mid-frame reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        loadVec(vecs[4]);

        // Largest image: 256 words, address wraps back to zero before CHK.
        frame_words.delete();
        for (int k = 0; k < 256; k++) frame_words.push_back({8'(k), ~8'(k), 8'h3C});
        applyStimulus(8'd255, 8'h00, 0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
